// File: rtl/debug_controller_if.sv
// rtl/debug_controller_if.sv - host-link, instruction-load, run-control and dump-read signals of the debug controller
interface debug_controller_if #(
  parameter int PC_BITS          = 11,
  parameter int INSTRUCTION_BITS = 32,
  parameter int PROC_BITS        = 32,
  parameter int DATA_ADDRS_BITS  = 11
);
  logic [7:0]                  i_rx_data;
  logic                        i_rx_valid;
  logic [7:0]                  o_tx_data;
  logic                        o_tx_valid;
  logic                        i_tx_ready;
  logic                        i_halt;
  logic                        o_enable;
  logic                        o_write_inst_mem;
  logic [PC_BITS-1:0]          o_inst_mem_addr;
  logic [INSTRUCTION_BITS-1:0] o_inst_mem_data;
  logic                        o_debug_read_data;
  logic [DATA_ADDRS_BITS-1:0]  o_debug_read_address;
  logic [PROC_BITS-1:0]        i_mem_data;

  modport slave (
    input  i_rx_data, i_rx_valid, i_tx_ready, i_halt, i_mem_data,
    output o_tx_data, o_tx_valid, o_enable, o_write_inst_mem,
           o_inst_mem_addr, o_inst_mem_data, o_debug_read_data, o_debug_read_address
  );

  modport master (
    output i_rx_data, i_rx_valid, i_tx_ready, i_halt, i_mem_data,
    input  o_tx_data, o_tx_valid, o_enable, o_write_inst_mem,
           o_inst_mem_addr, o_inst_mem_data, o_debug_read_data, o_debug_read_address
  );
endinterface

// File: rtl/debug_controller.sv
// rtl/debug_controller.sv - byte-command debug unit: program load, run/step control, cycle count and memory dump
module debug_controller #(
  parameter int                          PC_BITS          = 11,
  parameter int                          INSTRUCTION_BITS = 32,
  parameter int                          PROC_BITS        = 32,
  parameter int                          DATA_ADDRS_BITS  = 11,
  parameter int                          DUMP_WORDS       = 16,
  parameter logic [INSTRUCTION_BITS-1:0] HALT_INSTR       = 32'hFC000000
) (
  input  logic              clk,
  input  logic              rst,
  debug_controller_if.slave bus
);

  localparam int WIDX_BITS = $clog2(DUMP_WORDS + 1);

  typedef enum logic [3:0] {
    IDLE, LOAD, LOAD_WR, RUN, STEP_WAIT, STEP_EXEC,
    DUMP_CNT, DUMP_REQ, DUMP_SEND, DUMP_DONE
  } state_e;

  state_e                      state_q, state_d;
  logic [PC_BITS-1:0]          load_addr_q, load_addr_d;
  logic [1:0]                  byte_cnt_q, byte_cnt_d;
  logic [INSTRUCTION_BITS-1:0] instr_q, instr_d;
  logic [31:0]                 cycle_q, cycle_d;
  logic [WIDX_BITS-1:0]        word_idx_q, word_idx_d;
  logic [PROC_BITS-1:0]        shift_q, shift_d;
  logic [1:0]                  tx_cnt_q, tx_cnt_d;
  logic                        pending_q, pending_d;
  logic                        from_run_q, from_run_d;
  logic                        enable;

  always_comb begin
    state_d     = state_q;
    load_addr_d = load_addr_q;
    byte_cnt_d  = byte_cnt_q;
    instr_d     = instr_q;
    cycle_d     = cycle_q;
    word_idx_d  = word_idx_q;
    shift_d     = shift_q;
    tx_cnt_d    = tx_cnt_q;
    pending_d   = pending_q;
    from_run_d  = from_run_q;
    enable      = 1'b0;
    bus.o_tx_data            = '0;
    bus.o_tx_valid           = 1'b0;
    bus.o_write_inst_mem     = 1'b0;
    bus.o_inst_mem_addr      = '0;
    bus.o_inst_mem_data      = '0;
    bus.o_debug_read_data    = 1'b0;
    bus.o_debug_read_address = '0;

    case (state_q)
      IDLE: begin
        if (bus.i_rx_valid) begin
          case (bus.i_rx_data)
            8'h4C: begin
              load_addr_d = '0;
              byte_cnt_d  = '0;
              state_d     = LOAD;
            end
            8'h43: begin
              cycle_d    = '0;
              from_run_d = 1'b1;
              state_d    = RUN;
            end
            8'h53: begin
              cycle_d    = '0;
              from_run_d = 1'b0;
              state_d    = STEP_WAIT;
            end
            default: ;
          endcase
        end
      end
      LOAD: begin
        if (bus.i_rx_valid) begin
          instr_d    = {instr_q[INSTRUCTION_BITS-9:0], bus.i_rx_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) state_d = LOAD_WR;
        end
      end
      LOAD_WR: begin
        bus.o_write_inst_mem = 1'b1;
        bus.o_inst_mem_addr  = load_addr_q;
        bus.o_inst_mem_data  = instr_q;
        load_addr_d          = load_addr_q + 1'b1;
        byte_cnt_d           = '0;
        state_d              = (instr_q == HALT_INSTR) ? IDLE : LOAD;
      end
      RUN: begin
        enable = 1'b1;
        if (bus.i_halt) state_d = DUMP_CNT;
      end
      STEP_WAIT: begin
        if (bus.i_rx_valid) begin
          if (bus.i_rx_data == 8'h4E)      state_d = STEP_EXEC;
          else if (bus.i_rx_data == 8'h45) state_d = IDLE;
        end
      end
      STEP_EXEC: begin
        enable  = 1'b1;
        state_d = DUMP_CNT;
      end
      DUMP_CNT: begin
        shift_d    = PROC_BITS'(cycle_q);
        tx_cnt_d   = '0;
        word_idx_d = '0;
        pending_d  = 1'b0;
        state_d    = DUMP_SEND;
      end
      DUMP_REQ: begin
        bus.o_debug_read_data    = 1'b1;
        bus.o_debug_read_address = DATA_ADDRS_BITS'(word_idx_q);
        word_idx_d               = word_idx_q + 1'b1;
        pending_d                = 1'b1;
        tx_cnt_d                 = '0;
        state_d                  = DUMP_SEND;
      end
      DUMP_SEND: begin
        // The first cycle after a read request only captures the memory word.
        if (pending_q) begin
          shift_d   = bus.i_mem_data;
          pending_d = 1'b0;
        end else begin
          bus.o_tx_valid = 1'b1;
          bus.o_tx_data  = shift_q[PROC_BITS-1 -: 8];
          if (bus.i_tx_ready) begin
            shift_d  = {shift_q[PROC_BITS-9:0], 8'h00};
            tx_cnt_d = tx_cnt_q + 2'd1;
            if (tx_cnt_q == 2'd3)
              state_d = (word_idx_q == WIDX_BITS'(DUMP_WORDS)) ? DUMP_DONE : DUMP_REQ;
          end
        end
      end
      DUMP_DONE: begin
        state_d = (from_run_q || bus.i_halt) ? IDLE : STEP_WAIT;
      end
      default: state_d = IDLE;
    endcase

    if (enable && (cycle_q != 32'hFFFFFFFF)) cycle_d = cycle_q + 32'd1;
    bus.o_enable = enable;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      load_addr_q <= '0;
      byte_cnt_q  <= '0;
      instr_q     <= '0;
      cycle_q     <= '0;
      word_idx_q  <= '0;
      shift_q     <= '0;
      tx_cnt_q    <= '0;
      pending_q   <= 1'b0;
      from_run_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_addr_q <= load_addr_d;
      byte_cnt_q  <= byte_cnt_d;
      instr_q     <= instr_d;
      cycle_q     <= cycle_d;
      word_idx_q  <= word_idx_d;
      shift_q     <= shift_d;
      tx_cnt_q    <= tx_cnt_d;
      pending_q   <= pending_d;
      from_run_q  <= from_run_d;
    end
  end

endmodule
